sram_ctrl: RTL and testbench

Asynchronous external SRAM controller for the 6502 system bus, sitting between the CPU address decode for pages 30-3f and the FPGA SRAM pins. Converts a CPU-side chip-select/write strobe into properly sequenced CE/OE/WE pin cycles with parameterised wait states. Holds the CPU through a combinational `rdy` so slow parts work at full CPU clock. Registers read data for the data mux.

---
 rtl/sram_ctrl_pkg.sv | 40 ++++
 rtl/sram_ctrl.sv | 153 +++++++++++++++
 tb/tb_sram_ctrl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared definitions for the external SRAM controller.
// Holds the FSM state encoding, the strobe bundle type, the idle strobe
// pattern and the wait-counter width.
// Optional feature macro: SRAM_CTRL_TURNAROUND_EN (adds the TURN state).
package sram_ctrl_pkg;

  localparam int unsigned SRAM_CNT_W = 4;

  // {ce_n, oe_n, we_n} all inactive
  localparam logic [2:0] SRAM_STROBE_IDLE = 3'b111;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_RD       = 3'd1;
  localparam logic [2:0] ST_WR_SETUP = 3'd2;
  localparam logic [2:0] ST_WR_PULSE = 3'd3;
  localparam logic [2:0] ST_WR_HOLD  = 3'd4;
  localparam logic [2:0] ST_DONE     = 3'd5;
`ifdef SRAM_CTRL_TURNAROUND_EN
  localparam logic [2:0] ST_TURN     = 3'd6;
`endif

  typedef enum logic [2:0] {
    IDLE     = ST_IDLE,
    RD       = ST_RD,
    WR_SETUP = ST_WR_SETUP,
    WR_PULSE = ST_WR_PULSE,
    WR_HOLD  = ST_WR_HOLD,
    DONE     = ST_DONE
`ifdef SRAM_CTRL_TURNAROUND_EN
    , TURN   = ST_TURN
`endif
  } sram_state_t;

  typedef struct packed {
    logic ce_n;
    logic oe_n;
    logic we_n;
  } sram_strobe_t;

endpackage

// File: rtl/sram_ctrl.sv
// sram_ctrl: asynchronous external SRAM controller for the 6502 bus.
// Turns a CPU chip-select / write strobe into sequenced CE/OE/WE pin cycles
// with parameterised wait states, stalling the CPU through a combinational
// rdy. Read data is registered for the CPU data mux.
//
// Parameters: AW (address width), WAIT_RD (extra OE cycles, 0..15),
//             WAIT_WR (WE-low cycles, 1..15).
// Ports:
//   clk, reset (async, active-high)
//   cs, we, addr[AW], din[8]       CPU side request, sampled in IDLE only
//   dout[8]                        registered read data
//   rdy                            combinational, low stalls the CPU
//   sram_addr[AW], sram_dq_o[8], sram_dq_oe, sram_ce_n/oe_n/we_n  registered pins
//   sram_dq_i[8]                   pin read data
// Optional feature macro: SRAM_CTRL_TURNAROUND_EN inserts one dead TURN cycle
// after every write so FPGA drive never abuts an SRAM read drive.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned AW      = 16,
  parameter int unsigned WAIT_RD = 1,
  parameter int unsigned WAIT_WR = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cs,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic          rdy,
  output logic [AW-1:0] sram_addr,
  output logic [7:0]    sram_dq_o,
  output logic          sram_dq_oe,
  input  logic [7:0]    sram_dq_i,
  output logic          sram_ce_n,
  output logic          sram_oe_n,
  output logic          sram_we_n
);

  sram_state_t           state_q, state_d;
  logic [SRAM_CNT_W-1:0] cnt_q, cnt_d;
  sram_strobe_t          strobe_q, strobe_d;
  logic                  dq_oe_d;
  logic                  latch_c;
  logic                  capture_c;

  // Next state, counter and pin values; pins are decoded from the next state
  // so the registered strobes line up exactly with the state they belong to.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    latch_c   = 1'b0;
    capture_c = 1'b0;
    strobe_d  = sram_strobe_t'(SRAM_STROBE_IDLE);
    dq_oe_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (cs) begin
          latch_c = 1'b1;
          if (we) begin
            state_d = WR_SETUP;
          end else begin
            state_d = RD;
            cnt_d   = SRAM_CNT_W'(WAIT_RD);
          end
        end
      end
      RD: begin
        if (cnt_q == '0) begin
          capture_c = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q - SRAM_CNT_W'(1);
        end
      end
      WR_SETUP: begin
        state_d = WR_PULSE;
        cnt_d   = SRAM_CNT_W'(WAIT_WR - 1);
      end
      WR_PULSE: begin
        if (cnt_q == '0) begin
          state_d = WR_HOLD;
        end else begin
          cnt_d = cnt_q - SRAM_CNT_W'(1);
        end
      end
      WR_HOLD: begin
`ifdef SRAM_CTRL_TURNAROUND_EN
        state_d = TURN;
`else
        state_d = DONE;
`endif
      end
`ifdef SRAM_CTRL_TURNAROUND_EN
      TURN:    state_d = DONE;
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    case (state_d)
      RD: begin
        strobe_d.ce_n = 1'b0;
        strobe_d.oe_n = 1'b0;
      end
      WR_SETUP, WR_HOLD: begin
        strobe_d.ce_n = 1'b0;
        dq_oe_d       = 1'b1;
      end
      WR_PULSE: begin
        strobe_d.ce_n = 1'b0;
        strobe_d.we_n = 1'b0;
        dq_oe_d       = 1'b1;
      end
      default: ;
    endcase
  end

  // State, counter and pin registers; reset drops every strobe immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      strobe_q   <= sram_strobe_t'(SRAM_STROBE_IDLE);
      sram_dq_oe <= 1'b0;
      sram_addr  <= '0;
      sram_dq_o  <= '0;
      dout       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      strobe_q   <= strobe_d;
      sram_dq_oe <= dq_oe_d;
      if (latch_c) begin
        sram_addr <= addr;
        sram_dq_o <= din;
      end
      if (capture_c) begin
        dout <= sram_dq_i;
      end
    end
  end

  assign sram_ce_n = strobe_q.ce_n;
  assign sram_oe_n = strobe_q.oe_n;
  assign sram_we_n = strobe_q.we_n;

  // Only an idle controller with no request, or the completion cycle, lets the CPU go.
  assign rdy = ((state_q == IDLE) && !cs) || (state_q == DONE);

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: scoreboard bench for sram_ctrl. Three controllers with
// different wait-state settings each drive their own behavioural SRAM.
// Expected results are queued when an access is issued and compared when the
// controller signals completion. Honours SRAM_CTRL_TURNAROUND_EN.
module tb_sram_ctrl;

`ifdef SRAM_CTRL_TURNAROUND_EN
  localparam int TURN_EXP = 1;
`else
  localparam int TURN_EXP = 0;
`endif

  function automatic int unsigned wrd(int g);
    case (g)
      0:       return 1;
      1:       return 0;
      default: return 15;
    endcase
  endfunction

  function automatic int unsigned wwr(int g);
    case (g)
      0:       return 2;
      1:       return 1;
      default: return 15;
    endcase
  endfunction

  function automatic logic [7:0] pat(int k, logic [15:0] a);
    if (a == 16'h3012) return 8'hA5;
    return a[7:0] ^ a[15:8] ^ 8'(k * 37);
  endfunction

  logic        clk;
  logic        reset;
  logic        cs         [3];
  logic        we         [3];
  logic [15:0] addr       [3];
  logic [7:0]  din        [3];
  logic [7:0]  dout       [3];
  logic        rdy        [3];
  logic [15:0] sram_addr  [3];
  logic [7:0]  sram_dq_o  [3];
  logic        sram_dq_oe [3];
  logic [7:0]  sram_dq_i  [3];
  logic        sram_ce_n  [3];
  logic        sram_oe_n  [3];
  logic        sram_we_n  [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [7:0] mem [4096];

    sram_ctrl #(.AW(16), .WAIT_RD(wrd(g)), .WAIT_WR(wwr(g))) u_dut (
      .clk       (clk),
      .reset     (reset),
      .cs        (cs[g]),
      .we        (we[g]),
      .addr      (addr[g]),
      .din       (din[g]),
      .dout      (dout[g]),
      .rdy       (rdy[g]),
      .sram_addr (sram_addr[g]),
      .sram_dq_o (sram_dq_o[g]),
      .sram_dq_oe(sram_dq_oe[g]),
      .sram_dq_i (sram_dq_i[g]),
      .sram_ce_n (sram_ce_n[g]),
      .sram_oe_n (sram_oe_n[g]),
      .sram_we_n (sram_we_n[g])
    );

    // Async SRAM: reads while CE and OE are low, writes on the WE rising edge.
    assign sram_dq_i[g] = (!sram_ce_n[g] && !sram_oe_n[g]) ? mem[sram_addr[g][11:0]] : 8'hEE;

    initial begin
      for (int i = 0; i < 4096; i++) mem[i] = pat(g, 16'h3000 | 16'(i));
      forever begin
        @(posedge sram_we_n[g]);
        if (!sram_ce_n[g] && sram_dq_oe[g]) mem[sram_addr[g][11:0]] = sram_dq_o[g];
      end
    end
  end

  typedef struct {
    int         k;
    bit         wr;
    logic [7:0] data;
    int         lows;
    int         oe_lows;
    int         we_lows;
    int         turns;
  } exp_t;

  exp_t       sb [$];
  logic [7:0] ref_mem [3][4096];
  logic [7:0] last_rd [3];
  int         n_vec = 0;
  int         n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic access(input int k, input bit wr, input logic [15:0] a,
                        input logic [7:0] d, input bit scramble);
    exp_t  e;
    exp_t  x;
    int    lows;
    int    oe_lows;
    int    we_lows;
    int    turns;
    bit    pin_bad;
    bit    clash;
    bit    done;
    string t;
    e.k  = k;
    e.wr = wr;
    if (wr) begin
      ref_mem[k][a[11:0]] = d;
      e.data    = last_rd[k];
      e.lows    = int'(wwr(k)) + 3 + TURN_EXP;
      e.oe_lows = 0;
      e.we_lows = int'(wwr(k));
      e.turns   = TURN_EXP;
    end else begin
      e.data    = ref_mem[k][a[11:0]];
      last_rd[k] = e.data;
      e.lows    = int'(wrd(k)) + 2;
      e.oe_lows = int'(wrd(k)) + 1;
      e.we_lows = 0;
      e.turns   = 0;
    end
    sb.push_back(e);

    @(negedge clk);
    cs[k] = 1'b1; we[k] = wr; addr[k] = a; din[k] = d;
    #1;
    lows = rdy[k] ? 0 : 1;
    oe_lows = 0; we_lows = 0; turns = 0; pin_bad = 1'b0; clash = 1'b0; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (rdy[k]) begin
        done = 1'b1;
      end else begin
        lows++;
        if (!sram_oe_n[k]) oe_lows++;
        if (!sram_we_n[k]) we_lows++;
        if (sram_ce_n[k] && sram_oe_n[k] && sram_we_n[k] && !sram_dq_oe[k]) turns++;
        if (sram_addr[k] !== a) pin_bad = 1'b1;
        if (sram_dq_oe[k] && (sram_dq_o[k] !== d)) pin_bad = 1'b1;
        if (!sram_oe_n[k] && (sram_dq_oe[k] || !sram_we_n[k])) clash = 1'b1;
        if (!wr && sram_dq_oe[k]) clash = 1'b1;
        if (scramble) begin
          addr[k] = 16'($urandom);
          din[k]  = 8'($urandom);
          we[k]   = ~wr;
        end
      end
    end

    x = sb.pop_front();
    t = $sformatf("%s%0d@%h", x.wr ? "wr" : "rd", x.k, a);
    check({t, "_done"},    32'(done), 32'd1);
    check({t, "_rdy_low"}, 32'(lows), 32'(x.lows));
    check({t, "_oe_low"},  32'(oe_lows), 32'(x.oe_lows));
    check({t, "_we_low"},  32'(we_lows), 32'(x.we_lows));
    check({t, "_turn"},    32'(turns), 32'(x.turns));
    check({t, "_dout"},    32'(dout[x.k]), 32'(x.data));
    check({t, "_pins"},    32'(pin_bad), 32'd0);
    check({t, "_clash"},   32'(clash), 32'd0);
    check({t, "_done_pins"},
          32'({sram_ce_n[k], sram_oe_n[k], sram_we_n[k], sram_dq_oe[k]}), 32'b1110);
    cs[k] = 1'b0; we[k] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit reached;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cs[k] = 1'b0; we[k] = 1'b0; addr[k] = '0; din[k] = '0; last_rd[k] = '0;
      for (int i = 0; i < 4096; i++) ref_mem[k][i] = pat(k, 16'h3000 | 16'(i));
    end

    // Reset values
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("rst_strobes", 32'({sram_ce_n[k], sram_oe_n[k], sram_we_n[k]}), 32'b111);
      check("rst_dq_oe",   32'(sram_dq_oe[k]), 32'd0);
      check("rst_addr",    32'(sram_addr[k]), 32'd0);
      check("rst_dq_o",    32'(sram_dq_o[k]), 32'd0);
      check("rst_dout",    32'(dout[k]), 32'd0);
    end
    reset = 1'b0;

    // Reset asserted during the WE pulse
    @(negedge clk);
    cs[0] = 1'b1; we[0] = 1'b1; addr[0] = 16'h3400; din[0] = 8'h77;
    reached = 1'b0;
    for (int c = 0; c < 10 && !reached; c++) begin
      @(negedge clk);
      if (!sram_we_n[0]) reached = 1'b1;
    end
    check("rst_reach_pulse", 32'(reached), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rst_async_strobes", 32'({sram_ce_n[0], sram_oe_n[0], sram_we_n[0]}), 32'b111);
    check("rst_async_dq_oe",   32'(sram_dq_oe[0]), 32'd0);
    cs[0] = 1'b0; we[0] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_rel_dout",    32'(dout[0]), 32'd0);
    check("rst_rel_rdy",     32'(rdy[0]), 32'd1);
    check("rst_rel_strobes", 32'({sram_ce_n[0], sram_oe_n[0], sram_we_n[0], sram_dq_oe[0]}), 32'b1110);

    // Directed accesses on the default controller
    access(0, 1'b0, 16'h3012, 8'h00, 1'b0);
    access(0, 1'b1, 16'h3400, 8'h5C, 1'b0);
    access(0, 1'b0, 16'h3400, 8'h00, 1'b0);
    access(0, 1'b1, 16'h3500, 8'h81, 1'b0);
    access(0, 1'b0, 16'h3012, 8'h00, 1'b0);
    access(0, 1'b1, 16'h3600, 8'h3C, 1'b1);
    access(0, 1'b0, 16'h3600, 8'h00, 1'b1);

    // Wait-state extremes
    for (int k = 1; k < 3; k++) begin
      access(k, 1'b0, 16'h3012, 8'h00, 1'b0);
      access(k, 1'b1, 16'h3abc, 8'hC3, 1'b0);
      access(k, 1'b0, 16'h3abc, 8'h00, 1'b0);
      access(k, 1'b1, 16'h3abd, 8'h1E, 1'b1);
      access(k, 1'b0, 16'h3abd, 8'h00, 1'b0);
    end

    // Random mix over a small address window
    for (int i = 0; i < 16; i++) begin
      access(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
             16'h3800 + 16'($urandom_range(0, 7)), 8'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
